barrel_shift_pipe: RTL and testbench

- Parametrised, pipelined, multi-mode barrel shifter. Successor to the 16-bit combinational logarithmic right shifter.
- Supports logical right, arithmetic right, logical left and rotate right on a WIDTH-bit word.
- Has one register stage per shift level and a valid/ready handshake with full-pipeline stall on backpressure.
- Sits in the datapath between operand fetch and writeback, where a combinational 16-bit shifter no longer meets timing at wider widths.

---
 rtl/barrel_shift_pipe.sv | 140 ++++++++++++++
 tb/tb_barrel_shift_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// Pipelined multi-mode barrel shifter: one register stage per shift level,
// largest shift first, valid/ready handshake with a global stall.

module barrel_shift_stage #(
    parameter int WIDTH = 16,
    parameter int SHIFT = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sign,
    output logic [WIDTH-1:0] dout
);
    localparam int ROT = WIDTH - SHIFT;

    logic [WIDTH-1:0] fill;

    always_comb begin
        fill = sign ? ~({WIDTH{1'b1}} >> SHIFT) : '0;
        dout = din;
        if (en) begin
            case (mode)
                2'b00:   dout = din >> SHIFT;
                2'b01:   dout = (din >> SHIFT) | fill;
                2'b10:   dout = din << SHIFT;
                default: dout = (din >> SHIFT) | (din << ROT);
            endcase
        end
    end
endmodule

module barrel_shift_pipe #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] ctrl,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out
);
    localparam int S   = SHAMT_W;
    // Stage k keeps only the ctrl bits still needed downstream, so the
    // remaining-amount fields form a triangle packed into one vector.
    localparam int RCW = S * (S - 1) / 2;

    logic                   adv;
    logic [S-1:0]           vld_d, vld_q, nxt_vld;
    logic [S-1:0][WIDTH-1:0] data_d, data_q, nxt_data;
    logic [RCW-1:0]         rc_d, rc_q, nxt_rc;
    logic [S-2:0][1:0]      mode_d, mode_q, nxt_mode;
    logic [S-2:0]           sign_d, sign_q, nxt_sign;

    assign adv       = !vld_q[S-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[S-1];
    assign out       = data_q[S-1];

    genvar k;
    for (k = 0; k < S; k++) begin : g_stage
        localparam int N_IN = S - k;

        logic [N_IN-1:0]  rc_in;
        logic [1:0]       m_in;
        logic             s_in;
        logic             v_in;
        logic [WIDTH-1:0] d_in;

        if (k == 0) begin : g_src
            assign rc_in = ctrl;
            assign m_in  = mode;
            assign s_in  = in[WIDTH-1];
            assign v_in  = in_valid;
            assign d_in  = in;
        end else begin : g_src
            localparam int OFF_IN = (k - 1) * (S - 1) - (k - 1) * (k - 2) / 2;
            assign rc_in = rc_q[OFF_IN +: N_IN];
            assign m_in  = mode_q[k-1];
            assign s_in  = sign_q[k-1];
            assign v_in  = vld_q[k-1];
            assign d_in  = data_q[k-1];
        end

        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << (S - 1 - k))
        ) u_stage (
            .din  (d_in),
            .en   (rc_in[N_IN-1]),
            .mode (m_in),
            .sign (s_in),
            .dout (nxt_data[k])
        );

        assign nxt_vld[k] = v_in;

        if (k < S - 1) begin : g_meta
            localparam int OFF = k * (S - 1) - k * (k - 1) / 2;
            assign nxt_rc[OFF +: N_IN-1] = rc_in[N_IN-2:0];
            assign nxt_mode[k]           = m_in;
            assign nxt_sign[k]           = s_in;
        end
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        rc_d   = rc_q;
        mode_d = mode_q;
        sign_d = sign_q;
        if (adv) begin
            vld_d  = nxt_vld;
            data_d = nxt_data;
            rc_d   = nxt_rc;
            mode_d = nxt_mode;
            sign_d = nxt_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            rc_q   <= '0;
            mode_q <= '0;
            sign_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            rc_q   <= rc_d;
            mode_q <= mode_d;
            sign_q <= sign_d;
        end
    end
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed and random checks of barrel_shift_pipe at WIDTH=16 (latency 4).

module tb_barrel_shift_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic [3:0]  ctrl;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;

    barrel_shift_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .ctrl      (ctrl),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    bit          pend     = 0;
    bit          held_v   = 0;
    logic [15:0] held;
    bit          popped;
    int          n_sent, n_recv;
    string       cur_tag  = "data";
    bit          use_dir  = 0;
    logic [15:0] dir_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] a, input int s, input logic [1:0] m);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            case (m)
                2'd0:    r[i] = (i + s < 16) ? a[i+s] : 1'b0;
                2'd1:    r[i] = (i + s < 16) ? a[i+s] : a[15];
                2'd2:    r[i] = (i >= s) ? a[i-s] : 1'b0;
                default: r[i] = a[(i+s)%16];
            endcase
        end
        return r;
    endfunction

    // One clock: drive at the falling edge, then score both handshakes.
    task automatic step(input bit iv, input logic [15:0] d, input logic [3:0] c,
                        input logic [1:0] m, input bit ordy);
        @(negedge clk);
        if (held_v) begin
            chk("stall_hold", dout, held);
            held_v = 0;
        end
        out_ready = ordy;
        if (!pend) begin
            in_valid = iv;
            din      = d;
            ctrl     = c;
            mode     = m;
        end
        #1;
        popped = 0;
        if (out_valid && out_ready) begin
            popped = 1;
            n_recv++;
            if (exp_q.size() == 0) chk("spurious_qsize", exp_q.size(), 1);
            else chk(cur_tag, dout, exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
            n_sent++;
            exp_q.push_back(use_dir ? dir_exp : ref_shift(din, int'(ctrl), mode));
        end
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", in_ready, 0);
            held   = dout;
            held_v = 1;
        end
        pend = in_valid && !in_ready;
    endtask

    task automatic run_one(input string tag, input logic [15:0] a, input logic [3:0] c,
                           input logic [1:0] m, input logic [15:0] e);
        int lat;
        cur_tag = tag;
        use_dir = 1;
        dir_exp = e;
        step(1, a, c, m, 1);
        use_dir = 0;
        lat = 0;
        popped = 0;
        while (!popped && lat < 10) begin
            step(0, '0, '0, '0, 1);
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        cur_tag = "data";
    endtask

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  m;
        logic [15:0] e;
    } vec_t;

    vec_t vecs[11] = '{
        '{"srl4",    16'hF0F0, 4'd4,  2'd0, 16'h0F0F},
        '{"srl15",   16'h8000, 4'd15, 2'd0, 16'h0001},
        '{"sra3",    16'h8001, 4'd3,  2'd1, 16'hF000},
        '{"sra15p",  16'h7FFF, 4'd15, 2'd1, 16'h0000},
        '{"sra15n",  16'hFFFF, 4'd15, 2'd1, 16'hFFFF},
        '{"sll15",   16'h0001, 4'd15, 2'd2, 16'h8000},
        '{"ror4",    16'h1234, 4'd4,  2'd3, 16'h4123},
        '{"zero_srl",16'h1234, 4'd0,  2'd0, 16'h1234},
        '{"zero_sra",16'h1234, 4'd0,  2'd1, 16'h1234},
        '{"zero_sll",16'h1234, 4'd0,  2'd2, 16'h1234},
        '{"zero_ror",16'h1234, 4'd0,  2'd3, 16'h1234}
    };

    initial begin
        rst       = 1;
        in_valid  = 0;
        din       = '0;
        ctrl      = '0;
        mode      = '0;
        out_ready = 0;
        n_sent    = 0;
        n_recv    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", dout, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 0;

        foreach (vecs[i]) run_one(vecs[i].tag, vecs[i].a, vecs[i].c, vecs[i].m, vecs[i].e);

        // Streaming with a three-cycle backpressure window.
        n_sent  = 0;
        n_recv  = 0;
        cur_tag = "bp_order";
        for (int i = 0; i < 40 && n_recv < 8; i++)
            step(n_sent < 8, 16'hA5C3 ^ 16'(i * 16'h1111), 4'(i + 1), 2'(i), !(i >= 5 && i <= 7));
        chk("bp_count", n_recv, 8);
        chk("bp_qempty", exp_q.size(), 0);

        // Reset with three operands in flight.
        cur_tag = "data";
        for (int i = 0; i < 3; i++) step(1, 16'hBEEF, 4'(i + 2), 2'd1, 1);
        @(negedge clk);
        rst      = 1;
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out", dout, 0);
        exp_q.delete();
        pend   = 0;
        held_v = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, '0, '0, '0, 1);
            chk("midrst_stale", out_valid, 0);
        end
        run_one("post_rst", 16'h00F0, 4'd2, 2'd2, 16'h03C0);

        // Random traffic against the reference model.
        cur_tag = "rand";
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 9) < 7, 16'($urandom), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(0, '0, '0, '0, 1);
        chk("rand_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
